// File: rtl/rob_multi_commit.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback, up to COMMIT_W
// in-order retirements per cycle, with branch/JALR resolution and whole-machine flush at commit.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [1:0]                   alloc_type,
  input  logic [REG_W-1:0]             alloc_rd,
  input  logic [ADDR_W-1:0]            alloc_pc,
  input  logic                         alloc_pred,
  input  logic                         alloc_done,
  input  logic [DATA_W-1:0]            alloc_val,
  output logic [PTR_W-1:0]             alloc_tag,
  input  logic [2*PTR_W-1:0]           q_tag,
  output logic [1:0]                   q_ready,
  output logic [2*DATA_W-1:0]          q_val,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*PTR_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_val,
  input  logic [WB_PORTS-1:0]          wb_taken,
  input  logic [WB_PORTS*ADDR_W-1:0]   wb_target,
  output logic [COMMIT_W-1:0]          cm_valid,
  output logic [COMMIT_W*REG_W-1:0]    cm_rd,
  output logic [COMMIT_W*DATA_W-1:0]   cm_val,
  output logic [COMMIT_W*PTR_W-1:0]    cm_tag,
  output logic [COMMIT_W-1:0]          cm_store,
  output logic                         bp_valid,
  output logic [ADDR_W-1:0]            bp_pc,
  output logic                         bp_taken,
  output logic                         redirect,
  output logic [ADDR_W-1:0]            redirect_pc,
  output logic [PTR_W:0]               count
);
  localparam logic [1:0] T_BR = 2'd1, T_ST = 2'd2, T_JALR = 2'd3;

  logic [PTR_W-1:0]  head, tail;
  logic [DEPTH-1:0]  busy, done, pred, taken;
  logic [1:0]        typ    [DEPTH];
  logic [REG_W-1:0]  rd     [DEPTH];
  logic [ADDR_W-1:0] pc     [DEPTH];
  logic [ADDR_W-1:0] target [DEPTH];
  logic [DATA_W-1:0] val    [DEPTH];

  // Handshake: an entry is taken on an edge where alloc_valid && alloc_ready && rdy and no redirect is showing.
  logic alloc_fire;
  assign alloc_ready = (count < (PTR_W+1)'(DEPTH));
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;

  logic [PTR_W-1:0] qt;
  always_comb begin
    qt      = '0;
    q_ready = '0;
    q_val   = '0;
    for (int i = 0; i < 2; i++) begin
      qt = q_tag[i*PTR_W +: PTR_W];
      q_ready[i] = done[qt];
      q_val[i*DATA_W +: DATA_W] = val[qt];
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && wb_tag[p*PTR_W +: PTR_W] == qt) begin
          q_ready[i] = 1'b1;
          q_val[i*DATA_W +: DATA_W] = wb_val[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Contiguous done entries from head retire; a control op ends the group.
  logic [COMMIT_W-1:0]            go;
  logic [COMMIT_W-1:0][PTR_W-1:0] sidx;
  logic [PTR_W:0]                 n_go;
  logic                           ctl_go, stop, mispredict;
  logic [PTR_W-1:0]               ctl_idx;
  always_comb begin
    go      = '0;
    sidx    = '0;
    n_go    = '0;
    ctl_go  = 1'b0;
    ctl_idx = '0;
    stop    = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      sidx[k] = head + PTR_W'(k);
      if (!stop && ((PTR_W+1)'(k) < count) && done[sidx[k]]) begin
        go[k] = 1'b1;
        n_go  = n_go + (PTR_W+1)'(1);
        if (typ[sidx[k]] == T_BR || typ[sidx[k]] == T_JALR) begin
          ctl_go  = 1'b1;
          ctl_idx = sidx[k];
          stop    = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
    end
    mispredict = ctl_go && (typ[ctl_idx] == T_JALR || taken[ctl_idx] != pred[ctl_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      // The flush wins over rdy so fetch and the ROB never disagree after a redirect.
      head <= '0; tail <= '0; count <= '0;
      busy <= '0; done <= '0; pred <= '0; taken <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        typ[i] <= '0; rd[i] <= '0; pc[i] <= '0; target[i] <= '0; val[i] <= '0;
      end
      cm_valid <= '0; cm_rd <= '0; cm_val <= '0; cm_tag <= '0; cm_store <= '0;
      bp_valid <= 1'b0; bp_pc <= '0; bp_taken <= 1'b0;
      redirect <= 1'b0; redirect_pc <= '0;
    end else if (!rdy) begin
      cm_valid <= '0; cm_rd <= '0; cm_val <= '0; cm_tag <= '0; cm_store <= '0;
      bp_valid <= 1'b0; bp_pc <= '0; bp_taken <= 1'b0;
      redirect <= 1'b0; redirect_pc <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && busy[wb_tag[p*PTR_W +: PTR_W]]) begin
          done[wb_tag[p*PTR_W +: PTR_W]]   <= 1'b1;
          val[wb_tag[p*PTR_W +: PTR_W]]    <= wb_val[p*DATA_W +: DATA_W];
          taken[wb_tag[p*PTR_W +: PTR_W]]  <= wb_taken[p];
          target[wb_tag[p*PTR_W +: PTR_W]] <= wb_target[p*ADDR_W +: ADDR_W];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        cm_valid[k]                 <= go[k];
        cm_rd[k*REG_W +: REG_W]     <= go[k] ? rd[sidx[k]] : '0;
        cm_val[k*DATA_W +: DATA_W]  <= go[k] ? val[sidx[k]] : '0;
        cm_tag[k*PTR_W +: PTR_W]    <= go[k] ? sidx[k] : '0;
        cm_store[k]                 <= go[k] && typ[sidx[k]] == T_ST;
        if (go[k]) begin
          busy[sidx[k]] <= 1'b0;
          done[sidx[k]] <= 1'b0;
        end
      end
      bp_valid    <= ctl_go && typ[ctl_idx] == T_BR;
      bp_pc       <= (ctl_go && typ[ctl_idx] == T_BR) ? pc[ctl_idx] : '0;
      bp_taken    <= ctl_go && typ[ctl_idx] == T_BR && taken[ctl_idx];
      redirect    <= mispredict;
      redirect_pc <= mispredict ? target[ctl_idx] : '0;
      if (alloc_fire) begin
        busy[tail]   <= 1'b1;
        done[tail]   <= alloc_done;
        typ[tail]    <= alloc_type;
        rd[tail]     <= alloc_rd;
        pc[tail]     <= alloc_pc;
        pred[tail]   <= alloc_pred;
        taken[tail]  <= 1'b0;
        val[tail]    <= alloc_val;
        target[tail] <= '0;
      end
      head  <= head + n_go[PTR_W-1:0];
      tail  <= tail + PTR_W'(alloc_fire);
      count <= count + (PTR_W+1)'(alloc_fire) - n_go;
    end
  end
endmodule
